mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with burst lock, sharing one 4-bank RAM group between three requesters.
// Optional lock watchdog and lock_err output are built when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              req2,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              lock2,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    input  logic [31:0]       wdata2,
    input  logic [3:0]        we0,
    input  logic [3:0]        we1,
    input  logic [3:0]        we2,
    output logic [2:0]        gnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_data,
    output logic [3:0]        ram_we,
    input  logic [31:0]       ram_q,
    output logic [31:0]       rdata,
    output logic [2:0]        rvalid,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic              lock_err,
`endif
    output logic [1:0]        fsm_state
);

    // Handshake: a beat is any cycle with gnt[i] and req_i both high; gnt is registered,
    // the RAM port follows gnt combinationally, and read data returns RD_LAT cycles after its beat.
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, LOCKED = 2'd2} state_t;

    state_t      state, state_n;
    logic [2:0]  gnt_n;
    logic [2:0]  req_v, lock_v, own, tag;
    logic [1:0]  last_owner, last_n;
    logic        hold, timeout;
    logic [2:0]  sr [RD_LAT];

    assign req_v     = {req2, req1, req0};
    assign lock_v    = {lock2, lock1, lock0};
    assign own       = gnt & req_v;
    assign fsm_state = state;
    assign rdata     = ram_q;
    assign rvalid    = sr[RD_LAT-1];

    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [2:0] pick;
        pick = 3'b000;
        case (last)
            2'd0: if (r[1]) pick = 3'b010; else if (r[2]) pick = 3'b100; else if (r[0]) pick = 3'b001;
            2'd1: if (r[2]) pick = 3'b100; else if (r[0]) pick = 3'b001; else if (r[1]) pick = 3'b010;
            default: if (r[0]) pick = 3'b001; else if (r[1]) pick = 3'b010; else if (r[2]) pick = 3'b100;
        endcase
        return pick;
    endfunction

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] wd;
    // wd counts completed LOCKED cycles, so 254 marks the 255th one.
    assign timeout = (state == LOCKED) && (wd == 8'd254);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd       <= 8'd0;
            lock_err <= 1'b0;
        end else begin
            wd <= (state == LOCKED && state_n == LOCKED) ? wd + 8'd1 : 8'd0;
            if (timeout) lock_err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        last_n  = last_owner;
        hold    = (|(own & lock_v)) && !timeout;
        case (state)
            IDLE: begin
                if (|req_v) begin
                    gnt_n   = rr_pick(req_v, last_owner);
                    state_n = GRANT;
                end
            end
            GRANT, LOCKED: begin
                if (hold) begin
                    state_n = LOCKED;
                end else if (|req_v) begin
                    gnt_n   = rr_pick(req_v, last_owner);
                    state_n = GRANT;
                end else begin
                    gnt_n   = 3'b000;
                    state_n = IDLE;
                end
            end
            default: begin
                gnt_n   = 3'b000;
                state_n = IDLE;
            end
        endcase
        if (gnt_n != 3'b000 && gnt_n != gnt)
            last_n = gnt_n[2] ? 2'd2 : (gnt_n[1] ? 2'd1 : 2'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= 3'b000;
            last_owner <= 2'd2;
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            last_owner <= last_n;
        end
    end

    // Write enables are gated by req so a released grant never writes.
    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        ram_we   = 4'b0000;
        if (gnt[0]) begin
            ram_addr = addr0;
            ram_data = wdata0;
            ram_we   = req0 ? we0 : 4'b0000;
        end else if (gnt[1]) begin
            ram_addr = addr1;
            ram_data = wdata1;
            ram_we   = req1 ? we1 : 4'b0000;
        end else if (gnt[2]) begin
            ram_addr = addr2;
            ram_data = wdata2;
            ram_we   = req2 ? we2 : 4'b0000;
        end
    end

    assign tag = (ram_we == 4'b0000) ? own : 3'b000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < RD_LAT; k++) sr[k] <= 3'b000;
        end else begin
            sr[0] <= tag;
            for (int k = 1; k < RD_LAT; k++) sr[k] <= sr[k-1];
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural RAM of fixed read latency.
// The lock watchdog scenario is built only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

    localparam int ADDR_W = 14;
    localparam int RD_LAT = 2;

    logic              clk;
    logic              reset;
    logic              req0, req1, req2;
    logic              lock0, lock1, lock2;
    logic [ADDR_W-1:0] addr0, addr1, addr2;
    logic [31:0]       wdata0, wdata1, wdata2;
    logic [3:0]        we0, we1, we2;
    logic [2:0]        gnt;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_data;
    logic [3:0]        ram_we;
    logic [31:0]       ram_q;
    logic [31:0]       rdata;
    logic [2:0]        rvalid;
    logic [1:0]        fsm_state;
`ifdef MEM_ARB_TIMEOUT_EN
    logic              lock_err;
`endif

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .req2(req2),
        .lock0(lock0), .lock1(lock1), .lock2(lock2),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .we0(we0), .we1(we1), .we2(we2),
        .gnt(gnt), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .ram_q(ram_q), .rdata(rdata), .rvalid(rvalid),
`ifdef MEM_ARB_TIMEOUT_EN
        .lock_err(lock_err),
`endif
        .fsm_state(fsm_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: word a holds 32'hC0DE0000 | a after reset; reads return RD_LAT cycles later.
    logic [31:0]       mem [1<<ADDR_W];
    logic [ADDR_W-1:0] ap [RD_LAT];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 32'hC0DE_0000 | i;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_data[8*b +: 8];
        end
        ap[0] <= ram_addr;
        for (int k = 1; k < RD_LAT; k++) ap[k] <= ap[k-1];
    end

    assign ram_q = mem[ap[RD_LAT-1]];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Driver tasks
    task automatic clear_inputs();
        req0 = 0; req1 = 0; req2 = 0;
        lock0 = 0; lock1 = 0; lock2 = 0;
        addr0 = '0; addr1 = '0; addr2 = '0;
        wdata0 = '0; wdata1 = '0; wdata2 = '0;
        we0 = '0; we1 = '0; we2 = '0;
    endtask

    // Leaves the bench at posedge+1 of cycle 0 with the DUT idle.
    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        req0 = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b1;
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b exp 000", gnt); end
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b exp 000", rvalid); end
        checks++; if (ram_we !== 4'b0000) begin errors++; $display("FAIL reset_ram_we: got %b exp 0000", ram_we); end
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", fsm_state); end
`ifdef MEM_ARB_TIMEOUT_EN
        checks++; if (lock_err !== 1'b0) begin errors++; $display("FAIL reset_lock_err: got %b exp 0", lock_err); end
`endif
    endtask

    task automatic test_round_robin();
        logic [2:0]        exp_g [5];
        logic [ADDR_W-1:0] exp_a [5];
        exp_g = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
        exp_a = '{14'h0, 14'h11, 14'h22, 14'h33, 14'h11};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c > 0) next_cycle();
            req0 = 1; req1 = 1; req2 = 1;
            addr0 = 14'h11; addr1 = 14'h22; addr2 = 14'h33;
            @(negedge clk);
            checks++;
            if (gnt !== exp_g[c]) begin errors++; $display("FAIL rr_gnt c=%0d: got %b exp %b", c, gnt, exp_g[c]); end
            checks++;
            if (ram_addr !== exp_a[c]) begin errors++; $display("FAIL rr_addr c=%0d: got %h exp %h", c, ram_addr, exp_a[c]); end
        end
        next_cycle();
        clear_inputs();
        next_cycle();
        @(negedge clk);
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rr_idle_gnt: got %b exp 000", gnt); end
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL rr_idle_state: got %0d exp 0", fsm_state); end
    endtask

    task automatic test_read_pipeline();
        logic [2:0]  exp_g, exp_v;
        logic [31:0] exp_d;
        do_reset();
        for (int c = 0; c <= 4 + RD_LAT; c++) begin
            if (c > 0) next_cycle();
            req1  = (c <= 3);
            addr1 = (c >= 1 && c <= 3) ? ADDR_W'(4 + c) : ADDR_W'(5);
            @(negedge clk);
            exp_g = (c >= 1 && c <= 4) ? 3'b010 : 3'b000;
            exp_v = (c >= 1 + RD_LAT && c <= 3 + RD_LAT) ? 3'b010 : 3'b000;
            checks++;
            if (gnt !== exp_g) begin errors++; $display("FAIL rd_gnt c=%0d: got %b exp %b", c, gnt, exp_g); end
            checks++;
            if (rvalid !== exp_v) begin errors++; $display("FAIL rd_rvalid c=%0d: got %b exp %b", c, rvalid, exp_v); end
            if (exp_v != 3'b000) begin
                exp_d = 32'hC0DE_0000 | (4 + c - RD_LAT);
                checks++;
                if (rdata !== exp_d) begin errors++; $display("FAIL rd_data c=%0d: got %h exp %h", c, rdata, exp_d); end
            end
        end
    endtask

    task automatic test_lock_burst();
        logic [2:0] exp_g;
        do_reset();
        for (int c = 0; c <= 13; c++) begin
            if (c > 0) next_cycle();
            req2  = (c <= 11);
            lock2 = (c <= 10);
            req0  = (c >= 1);
            @(negedge clk);
            exp_g = (c == 0) ? 3'b000 : ((c <= 11) ? 3'b100 : 3'b001);
            checks++;
            if (gnt !== exp_g) begin errors++; $display("FAIL lock_gnt c=%0d: got %b exp %b", c, gnt, exp_g); end
            if (c == 6) begin
                checks++;
                if (fsm_state !== 2'd2) begin errors++; $display("FAIL lock_state: got %0d exp 2", fsm_state); end
            end
        end
    endtask

    task automatic test_write_read();
        do_reset();
        for (int c = 0; c <= 3 + RD_LAT; c++) begin
            if (c > 0) next_cycle();
            req0   = (c <= 2);
            we0    = (c <= 1) ? 4'b1111 : 4'b0000;
            wdata0 = 32'hA1B2_C3D4;
            addr0  = 14'h10;
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (ram_we !== 4'b1111) begin errors++; $display("FAIL wr_we: got %b exp 1111", ram_we); end
                checks++;
                if (ram_data !== 32'hA1B2_C3D4) begin errors++; $display("FAIL wr_data: got %h exp a1b2c3d4", ram_data); end
                checks++;
                if (ram_addr !== 14'h10) begin errors++; $display("FAIL wr_addr: got %h exp 0010", ram_addr); end
            end
            if (c == 1 + RD_LAT) begin
                checks++;
                if (rvalid !== 3'b000) begin errors++; $display("FAIL wr_no_rvalid: got %b exp 000", rvalid); end
            end
            if (c == 2 + RD_LAT) begin
                checks++;
                if (rvalid !== 3'b001) begin errors++; $display("FAIL wr_rd_rvalid: got %b exp 001", rvalid); end
                checks++;
                if (rdata !== 32'hA1B2_C3D4) begin errors++; $display("FAIL wr_rd_data: got %h exp a1b2c3d4", rdata); end
            end
        end
    endtask

    task automatic test_drop_req();
        do_reset();
        req1 = 1'b1; we1 = 4'b1111; addr1 = 14'h40; wdata1 = 32'hDEAD_BEEF;
        next_cycle();
        req1 = 1'b0;
        @(negedge clk);
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL drop_gnt_held: got %b exp 010", gnt); end
        checks++; if (ram_we !== 4'b0000) begin errors++; $display("FAIL drop_no_write: got %b exp 0000", ram_we); end
        next_cycle();
        @(negedge clk);
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL drop_release: got %b exp 000", gnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0 = 1'b1; addr0 = 14'h7;
        next_cycle();
        @(negedge clk);
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL midrst_beat: got %b exp 001", gnt); end
        next_cycle();
        reset = 1'b1;
        req0  = 1'b0;
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL midrst_gnt: got %b exp 000", gnt); end
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < RD_LAT + 3; c++) begin
            @(negedge clk);
            checks++;
            if (rvalid !== 3'b000) begin errors++; $display("FAIL midrst_rvalid c=%0d: got %b exp 000", c, rvalid); end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  exp_v;
        logic [31:0] exp_d;
        do_reset();
        for (int c = 0; c <= 4 + RD_LAT; c++) begin
            if (c > 0) next_cycle();
            req0 = (c <= 3); req1 = (c <= 3); req2 = (c <= 3);
            addr0 = 14'h20; addr1 = 14'h21; addr2 = 14'h22;
            @(negedge clk);
            if (c >= 1 + RD_LAT) begin
                case (c - RD_LAT)
                    1: begin exp_v = 3'b001; exp_d = 32'hC0DE_0020; end
                    2: begin exp_v = 3'b010; exp_d = 32'hC0DE_0021; end
                    3: begin exp_v = 3'b100; exp_d = 32'hC0DE_0022; end
                    default: begin exp_v = 3'b000; exp_d = 32'h0; end
                endcase
                checks++;
                if (rvalid !== exp_v) begin errors++; $display("FAIL b2b_rvalid c=%0d: got %b exp %b", c, rvalid, exp_v); end
                if (exp_v != 3'b000) begin
                    checks++;
                    if (rdata !== exp_d) begin errors++; $display("FAIL b2b_data c=%0d: got %h exp %h", c, rdata, exp_d); end
                end
            end
        end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_watchdog();
        int first_switch;
        first_switch = -1;
        do_reset();
        req1 = 1'b1; lock1 = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            next_cycle();
            req0 = 1'b1;
            @(negedge clk);
            if (gnt === 3'b001 && first_switch < 0) first_switch = c;
            if (c == 100) begin
                checks++;
                if (lock_err !== 1'b0) begin errors++; $display("FAIL wd_early_err: got %b exp 0", lock_err); end
            end
        end
        checks++;
        if (first_switch != 257) begin errors++; $display("FAIL wd_switch_cycle: got %0d exp 257", first_switch); end
        checks++;
        if (lock_err !== 1'b1) begin errors++; $display("FAIL wd_lock_err: got %b exp 1", lock_err); end
        do_reset();
        checks++;
        if (lock_err !== 1'b0) begin errors++; $display("FAIL wd_err_clear: got %b exp 0", lock_err); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_read_pipeline();
        test_lock_burst();
        test_write_read();
        test_drop_req();
        test_reset_mid();
        test_back_to_back();
`ifdef MEM_ARB_TIMEOUT_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
